// File: rtl/pdm_pkg.sv
// Shared constants and width helpers for the PDM microphone receive path.
package pdm_pkg;

   localparam int CIC_ORDER = 2;
   localparam int SAMPLE_W  = 8;

   function automatic int cic_width(input int decim_log2);
      return 2 * decim_log2 + 2;
   endfunction

   function automatic int out_shift(input int decim_log2);
      return 2 * decim_log2 - 7;
   endfunction

endpackage

// File: rtl/pdm_mic_rx_cic2_decimator.sv
// Order-2 CIC decimator: integrators run per PDM bit, the comb runs once per frame
// and its result is rescaled and clipped to a signed 8-bit sample.
module cic2_decimator
   import pdm_pkg::*;
#(
   parameter int DECIM_LOG2 = 6
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clear_i,
   input  logic                       bit_stb_i,
   input  logic                       bit_i,
   input  logic                       frame_stb_i,
   output logic signed [SAMPLE_W-1:0] sample_o,
   output logic                       valid_o,
   output logic                       sat_o
);

   localparam int W     = cic_width(DECIM_LOG2);
   localparam int SHIFT = out_shift(DECIM_LOG2);
   localparam logic signed [W-1:0] Y_MAX = W'(127);

   logic signed [W-1:0]        i1_q, i1_d, i2_q, i2_d;
   logic signed [W-1:0]        i2_dly_q, c1_dly_q;
   logic signed [W-1:0]        x, c1, c2, y;
   logic                       frame_q, valid_q, sat_q, sat_d;
   logic signed [SAMPLE_W-1:0] sample_q, sample_d;

   // Integrators wrap modulo 2^W; the comb difference recovers the exact value.
   always_comb begin
      x        = bit_i ? W'(1) : '1;
      i1_d     = i1_q;
      i2_d     = i2_q;
      if (bit_stb_i) begin
         i1_d = i1_q + x;
         i2_d = i2_q + i1_q;
      end
      c1       = i2_q - i2_dly_q;
      c2       = c1 - c1_dly_q;
      y        = c2 >>> SHIFT;
      sat_d    = (y > Y_MAX);
      sample_d = sat_d ? 8'sd127 : y[SAMPLE_W-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         i1_q     <= '0;
         i2_q     <= '0;
         i2_dly_q <= '0;
         c1_dly_q <= '0;
         frame_q  <= 1'b0;
         valid_q  <= 1'b0;
         sat_q    <= 1'b0;
         sample_q <= '0;
      end else if (clear_i) begin
         i1_q     <= '0;
         i2_q     <= '0;
         i2_dly_q <= '0;
         c1_dly_q <= '0;
         frame_q  <= 1'b0;
         valid_q  <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         i1_q    <= i1_d;
         i2_q    <= i2_d;
         frame_q <= frame_stb_i;
         valid_q <= frame_q;
         sat_q   <= frame_q & sat_d;
         if (frame_q) begin
            i2_dly_q <= i2_q;
            c1_dly_q <= c1;
            sample_q <= sample_d;
         end
      end
   end

   assign sample_o = sample_q;
   assign valid_o  = valid_q;
   assign sat_o    = sat_q;

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: drives the mic clock, captures one bit per mic clock
// period and hands the bit stream to the CIC decimator.
module pdm_mic_rx
   import pdm_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int DECIM_LOG2 = 6
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       en_in,
   input  logic                       mic_data_in,
   output logic                       mic_clk_out,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       sample_valid_out,
   output logic                       sat_out
);

   localparam int DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic [DECIM_LOG2-1:0] dec_cnt_q, dec_cnt_d;
   logic                  mic_clk_q, mic_clk_d;
   logic [1:0]            sync_q;
   logic                  div_term, bit_stb, frame_stb;

   assign div_term  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
   assign bit_stb   = en_in & div_term & mic_clk_q;
   assign frame_stb = bit_stb & (&dec_cnt_q);

   // Dropping the enable parks the divider so a re-enable starts a fresh low phase.
   always_comb begin
      div_cnt_d = div_cnt_q;
      mic_clk_d = mic_clk_q;
      dec_cnt_d = dec_cnt_q;
      if (!en_in) begin
         div_cnt_d = '0;
         mic_clk_d = 1'b0;
         dec_cnt_d = '0;
      end else begin
         if (div_term) begin
            div_cnt_d = '0;
            mic_clk_d = ~mic_clk_q;
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end
         if (bit_stb) begin
            dec_cnt_d = dec_cnt_q + DECIM_LOG2'(1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         div_cnt_q <= '0;
         mic_clk_q <= 1'b0;
         dec_cnt_q <= '0;
         sync_q    <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         mic_clk_q <= mic_clk_d;
         dec_cnt_q <= dec_cnt_d;
         sync_q    <= {sync_q[0], mic_data_in};
      end
   end

   assign mic_clk_out = mic_clk_q;

   cic2_decimator #(
      .DECIM_LOG2 (DECIM_LOG2)
   ) u_cic (
      .clk_i       (clk_in),
      .rst_ni      (rst_in),
      .clear_i     (~en_in),
      .bit_stb_i   (bit_stb),
      .bit_i       (sync_q[1]),
      .frame_stb_i (frame_stb),
      .sample_o    (sample_out),
      .valid_o     (sample_valid_out),
      .sat_o       (sat_out)
   );

endmodule
